// File: rtl/is_div_3_seq_ctrl.sv
// is_div_3_seq_ctrl
// Decides whether a SIZE-bit unsigned operand is divisible by 3. The operand
// is consumed CHUNK bits per clock, MSB first, through one 2-bit mod-3
// accumulator. It trades latency (SIZE/CHUNK cycles) for a small datapath.
//
// Parameters:
//   SIZE  - operand width; a multiple of CHUNK
//   CHUNK - bits consumed per RUN cycle
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous reset, active high
//   in_valid  - operand present on digit
//   in_ready  - operand accepted this cycle when in_valid is also high
//   digit     - unsigned operand
//   out_valid - result valid, held until out_ready
//   out_ready - consumer takes the result
//   out       - 1 when the operand is divisible by 3
//   busy      - high while the operand is being reduced
//   rem_out   - final remainder, 0..2 (only when IS_DIV_3_REM_EN is defined)
//
// Optional build macro: IS_DIV_3_REM_EN adds the rem_out port.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | reducing one CHUNK per cycle, busy high
// DONE  | result presented, waiting for out_ready

module is_div_3_seq_ctrl #(
   parameter int SIZE  = 8,
   parameter int CHUNK = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] digit,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out,
`ifdef IS_DIV_3_REM_EN
   output logic [1:0]      rem_out,
`endif
   output logic            busy
);

   localparam int N_STEPS = SIZE / CHUNK;
   localparam int CNT_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
   // Holds 2*2 + (2^CHUNK - 1) without overflow.
   localparam int ACC_W   = CHUNK + 3;
   // 2^CHUNK mod 3 is 1 for even CHUNK and 2 for odd CHUNK.
   localparam logic [ACC_W-1:0] WEIGHT   = (CHUNK % 2 == 0) ? ACC_W'(1) : ACC_W'(2);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N_STEPS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [1:0]        rem_q, rem_d;
   logic [SIZE-1:0]   shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              out_valid_q, out_valid_d;
   logic              out_q, out_d;
`ifdef IS_DIV_3_REM_EN
   logic [1:0]        rem_out_q, rem_out_d;
`endif

   logic [ACC_W-1:0]  acc_sum;
   logic [1:0]        rem_step;
   logic              accept;

   // State register and datapath flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rem_q       <= 2'd0;
         shift_q     <= '0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_q       <= 1'b0;
`ifdef IS_DIV_3_REM_EN
         rem_out_q   <= 2'd0;
`endif
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         shift_q     <= shift_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
`ifdef IS_DIV_3_REM_EN
         rem_out_q   <= rem_out_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = RUN;
         RUN:     if (cnt_q == '0) state_d = DONE;
         DONE:    if (out_ready) state_d = in_valid ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE:    in_ready = 1'b1;
         RUN:     busy     = 1'b1;
         // Consuming the result frees the accumulator in the same cycle.
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   assign accept   = in_valid && in_ready;
   assign acc_sum  = ACC_W'(rem_q) * WEIGHT + ACC_W'(shift_q[SIZE-1 -: CHUNK]);
   assign rem_step = 2'(acc_sum % ACC_W'(3));

   // Datapath next values.
   always_comb begin
      shift_d     = shift_q;
      rem_d       = rem_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
`ifdef IS_DIV_3_REM_EN
      rem_out_d   = rem_out_q;
`endif
      if (state_q == DONE && out_ready) begin
         out_valid_d = 1'b0;
         out_d       = 1'b0;
`ifdef IS_DIV_3_REM_EN
         rem_out_d   = 2'd0;
`endif
      end
      if (accept) begin
         shift_d = digit;
         rem_d   = 2'd0;
         cnt_d   = CNT_LOAD;
      end else if (state_q == RUN) begin
         shift_d = shift_q << CHUNK;
         rem_d   = rem_step;
         if (cnt_q == '0) begin
            out_valid_d = 1'b1;
            out_d       = (rem_step == 2'd0);
`ifdef IS_DIV_3_REM_EN
            rem_out_d   = rem_step;
`endif
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
`ifdef IS_DIV_3_REM_EN
   assign rem_out   = rem_out_q;
`endif

endmodule

// File: tb/tb_is_div_3_seq_ctrl.sv
module tb_is_div_3_seq_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // cfg0: SIZE=8 CHUNK=2, cfg1: SIZE=8 CHUNK=1, cfg2: SIZE=4 CHUNK=4
   for (genvar g = 0; g < 3; g++) begin : g_cfg
      localparam int SZ = (g == 2) ? 4 : 8;
      localparam int CK = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
      localparam int NS = SZ / CK;

      logic          rst_g     = 1'b1;
      logic          in_valid  = 1'b0;
      logic          out_ready = 1'b0;
      logic [SZ-1:0] digit     = '0;
      logic          in_ready, out_valid, out, busy;
`ifdef IS_DIV_3_REM_EN
      logic [1:0]    rem_out;
`endif
      logic [1:0]    sb_rem[$];
      int            sb_acc[$];
      bit            done = 1'b0;
      int            busy_cnt = 0;
      bit            prev_ov = 1'b0;

      is_div_3_seq_ctrl #(.SIZE(SZ), .CHUNK(CK)) u_dut (
         .clk       (clk),
         .rst       (rst_g),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .digit     (digit),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out       (out),
`ifdef IS_DIV_3_REM_EN
         .rem_out   (rem_out),
`endif
         .busy      (busy)
      );

      // Present an operand until accepted; expected remainder goes to the scoreboard.
      task automatic send(input logic [SZ-1:0] v, input logic [1:0] exp_rem,
                          input bit push, output int waited);
         waited   = 0;
         in_valid = 1'b1;
         digit    = v;
         @(negedge clk);
         while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
         end
         if (!in_ready) chk($sformatf("cfg%0d_accept_timeout", g), 0, 1);
         else if (push) begin
            sb_rem.push_back(exp_rem);
            sb_acc.push_back(cyc + 1);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         digit    = ~v;
      endtask

      task automatic drain();
         int t = 0;
         while (sb_rem.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
         end
         if (sb_rem.size() != 0) begin
            chk($sformatf("cfg%0d_drain_timeout", g), sb_rem.size(), 0);
            sb_rem.delete();
            sb_acc.delete();
         end
         @(posedge clk);
         #1;
      endtask

      task automatic chk_reset_outs(input string tag);
         chk({tag, "_in_ready"}, int'(in_ready), 1);
         chk({tag, "_out_valid"}, int'(out_valid), 0);
         chk({tag, "_out"}, int'(out), 0);
         chk({tag, "_busy"}, int'(busy), 0);
`ifdef IS_DIV_3_REM_EN
         chk({tag, "_rem_out"}, int'(rem_out), 0);
`endif
      endtask

      // Monitor: pops the scoreboard on each output handshake.
      initial forever begin
         @(negedge clk);
         if (rst_g) begin
            busy_cnt = 0;
            prev_ov  = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (out_valid && !prev_ov) begin
               if (sb_rem.size() == 0)
                  chk($sformatf("cfg%0d_unexpected_out_valid", g), 1, 0);
               else begin
                  chk($sformatf("cfg%0d_latency", g), cyc - sb_acc[0], NS);
                  chk($sformatf("cfg%0d_busy_cycles", g), busy_cnt, NS);
               end
               busy_cnt = 0;
            end
            if (out_valid && sb_rem.size() != 0) begin
               chk($sformatf("cfg%0d_out", g), int'(out), int'(sb_rem[0] == 2'd0));
`ifdef IS_DIV_3_REM_EN
               chk($sformatf("cfg%0d_rem_out", g), int'(rem_out), int'(sb_rem[0]));
`endif
               if (out_ready) begin
                  void'(sb_rem.pop_front());
                  void'(sb_acc.pop_front());
               end else begin
                  chk($sformatf("cfg%0d_in_ready_held", g), int'(in_ready), 0);
               end
            end else if (!out_valid) begin
               chk($sformatf("cfg%0d_out_idle", g), int'(out), 0);
            end
            prev_ov = out_valid;
         end
      end

      if (g == 0) begin : g_stim
         initial begin
            int w;
            #1;
            chk_reset_outs("cfg0_reset");
            repeat (3) @(posedge clk);
            #1 rst_g = 1'b0;
            out_ready = 1'b1;
            send(8'h00, 2'd0, 1'b1, w);
            chk("cfg0_first_accept_wait", w, 0);
            send(8'hFF, 2'd0, 1'b1, w);
            send(8'h07, 2'd1, 1'b1, w);
            send(8'hAA, 2'd2, 1'b1, w);
            drain();
            // Backpressure: result of 9 held for several cycles.
            out_ready = 1'b0;
            send(8'd9, 2'd0, 1'b1, w);
            repeat (NS + 5) @(posedge clk);
            #1;
            chk("cfg0_backpressure_out_valid", int'(out_valid), 1);
            chk("cfg0_backpressure_out", int'(out), 1);
            out_ready = 1'b1;
            send(8'd10, 2'd1, 1'b1, w);
            chk("cfg0_same_cycle_accept", w, 0);
            drain();
            // Abort 2 cycles into RUN.
            send(8'd3, 2'd0, 1'b0, w);
            @(posedge clk);
            #1;
            chk("cfg0_busy_before_abort", int'(busy), 1);
            rst_g = 1'b1;
            #1;
            chk_reset_outs("cfg0_abort");
            repeat (2) @(posedge clk);
            #1 rst_g = 1'b0;
            repeat (NS + 4) @(posedge clk);
            #1;
            send(8'd6, 2'd0, 1'b1, w);
            drain();
            done = 1'b1;
         end
      end else if (g == 1) begin : g_stim
         initial forever begin
            @(posedge clk);
            #1 out_ready = 1'($urandom_range(0, 1));
         end
         initial begin
            int w;
            repeat (3) @(posedge clk);
            #1 rst_g = 1'b0;
            for (int i = 0; i < 256; i++) send(SZ'(i), 2'(i % 3), 1'b1, w);
            drain();
            done = 1'b1;
         end
      end else begin : g_stim
         initial begin
            int w;
            repeat (3) @(posedge clk);
            #1 rst_g = 1'b0;
            out_ready = 1'b1;
            send(4'hC, 2'd0, 1'b1, w);
            send(4'hD, 2'd1, 1'b1, w);
            drain();
            done = 1'b1;
         end
      end
   end

   initial begin
      while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && cyc < 30000)
         @(posedge clk);
      if (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done))
         chk("global_timeout", 0, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/is_div_3_seq_ctrl.md
Name: is_div_3_seq_ctrl

Overview:
- Sequential controller that decides whether a SIZE-bit unsigned word is divisible by 3.
- Processes CHUNK bits per clock, MSB-first, through one shared 2-bit mod-3 accumulator.
- Replaces the wide combinational reduction tree where area matters more than latency.
- Sits between a valid/ready producer and consumer; one operand in flight at a time.

Parameters:
- SIZE, 8, operand width in bits; must be a multiple of CHUNK and ≥ CHUNK.
- CHUNK, 2, bits consumed per RUN cycle; 1 ≤ CHUNK ≤ SIZE.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand available on digit.
- in_ready  output  1  controller accepts the operand this cycle.
- digit  input  SIZE  unsigned operand.
- out_valid  output  1  result valid; held until consumed.
- out_ready  input  1  consumer accepts the result.
- out  output  1  1 if the operand is divisible by 3, else 0.
- busy  output  1  high while in RUN.

Behaviour:
- Reset is asynchronous, active-high. While rst is asserted and after release:
  - state = IDLE; in_ready = 1; out_valid = 0; out = 0; busy = 0.
  - Accumulator rem = 0, shift register = 0, chunk counter = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid: latch digit into the shift register, clear rem, load counter = SIZE/CHUNK - 1, go to RUN.
- RUN:
  - in_ready = 0; busy = 1.
  - Each cycle: c = top CHUNK bits of the shift register; rem <= (rem*W + c) mod 3.
    - W = 1 if CHUNK is even, W = 2 if CHUNK is odd.
    - Intermediate width must hold 2*2 + (2^CHUNK - 1) with no overflow.
  - Shift register shifts left by CHUNK each cycle; counter decrements.
  - When counter == 0 the final rem update happens and the state goes to DONE.
  - Exactly SIZE/CHUNK cycles are spent in RUN.
- DONE:
  - out_valid = 1; out = (rem == 0). Both are registered and stable until the handshake.
  - On out_ready, the result is consumed:
    - If in_valid is also high, the new operand is accepted in the same cycle (in_ready = out_ready in DONE) and the state goes to RUN.
    - Otherwise the state goes to IDLE.
  - If out_ready = 0, stay in DONE; in_ready = 0.
- Latency: operand accepted at edge N, out_valid high from edge N + SIZE/CHUNK.
- Throughput: one result per SIZE/CHUNK + 1 cycles when out_ready is held high.
- Changes to in_valid/digit while not accepting are ignored; the operand is captured only at acceptance.
- Reset mid-RUN or mid-DONE aborts immediately: the pending result is dropped and no out_valid pulse follows.
- SIZE == CHUNK: one RUN cycle.
- out is 0 whenever out_valid = 0.

Optional Feature:
- Macro: IS_DIV_3_REM_EN.
- Defined:
  - Adds output port rem_out[1:0] holding the final remainder (0..2).
  - Valid and stable with out_valid; 0 at reset and whenever out_valid = 0.
  - out == (rem_out == 0) always holds.
- Undefined: port absent; the accumulator is internal only; behaviour otherwise identical.

Test Plan:
- SIZE=8, CHUNK=2. Reset, then digit=0 with in_valid → in_ready=1 at acceptance; busy 4 cycles; out_valid at acceptance+4 with out=1 (rem_out=0).
- digit=8'hFF (255) → out=1; digit=8'h07 (7) → out=0, rem_out=1; digit=8'hAA (170) → out=0, rem_out=2.
- Backpressure: result of 9 held with out_ready=0 for 5 cycles → out_valid and out=1 stable, in_ready=0. Then out_ready=1 with in_valid=1 and digit=10 → same-cycle accept, next result out=0, rem_out=1.
- Assert rst 2 cycles into RUN on digit=3 → outputs at reset values immediately; no out_valid follows; next operand 6 → out=1.
- CHUNK=1 (odd weight), SIZE=8: exhaustive 0..255 with random out_ready → out == (x%3==0) and 8 RUN cycles for every operand.
- SIZE=CHUNK=4: digit=4'hC (12) → one RUN cycle, out=1; digit=4'hD (13) → out=0.
